multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing controller for the RISC-V datapath, converting it from single-cycle to multi-cycle operation.
- Captures the instruction opcode and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the datapath control strobes (MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite, ALUOp) plus PC and IR write enables.
- Stalls on a data-memory ready handshake and counts retired instructions; the existing ALUController still consumes ALUOp.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter
OP_RTYPE, 7'b0110011, R-type ALU opcode
OP_ITYPE, 7'b0010011, I-type ALU opcode
OP_LOAD, 7'b0000011, LW opcode
OP_STORE, 7'b0100011, SW opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  1 = sequencing enabled; 0 = hold in FETCH with no strobes
Opcode  input  7  instruction[6:0] from the datapath
mem_ready  input  1  data memory completed the access this cycle
pc_write  output  1  PC <- PC+4 strobe
ir_write  output  1  instruction register load strobe
MemtoReg  output  1  write-back mux select (1 = memory data)
MemWrite  output  1  data memory write strobe
MemRead  output  1  data memory read strobe
ALUSrc  output  1  ALU operand B select (1 = immediate)
RegWrite  output  1  register file write strobe
ALUOp  output  2  to ALUController: 00 add (LW/SW), 10 R/I-type via funct
illegal_instr  output  1  one-cycle pulse on an unsupported opcode
state  output  3  current state, for debug
instr_count  output  COUNT_WIDTH  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4. Codes 5-7 are unreachable and recover to FETCH on the next edge.
- Reset (async, any time, including mid-instruction): state=FETCH, latched opcode=0, instr_count=0, illegal_instr=0.
- Outputs are Moore-style, decoded from state plus the latched opcode, so every strobe is 0 while reset is asserted.
- Any transaction in flight at reset is abandoned with no retirement.
- FETCH:
  - If run=1: pc_write=1 and ir_write=1 for exactly one cycle, then go to DECODE.
  - If run=0: all strobes 0, stay in FETCH.
- DECODE:
  - Latch Opcode into the internal op register.
  - If the opcode is not one of the four supported values: pulse illegal_instr=1, return to FETCH, do not count.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - ALUSrc = 1 for ITYPE/LOAD/STORE, 0 for RTYPE.
  - ALUOp = 00 for LOAD/STORE, 10 for RTYPE/ITYPE.
  - Next state: MEM for LOAD/STORE, WRITEBACK for RTYPE/ITYPE.
- MEM:
  - MemRead=1 (LOAD) or MemWrite=1 (STORE); ALUSrc and ALUOp held at their EXECUTE values.
  - Stay in MEM while mem_ready=0, with strobes held steady.
  - On mem_ready=1: LOAD goes to WRITEBACK; STORE retires and goes to FETCH.
- WRITEBACK:
  - RegWrite=1 for exactly one cycle; MemtoReg=1 for LOAD, 0 otherwise.
  - ALUSrc and ALUOp held at their EXECUTE values.
  - Retire, then go to FETCH.
- Latency, with run=1 and zero wait states:
  - R/I-type: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each mem_ready=0 cycle adds 1.
- run is sampled only in FETCH; deasserting it mid-instruction has no effect until the instruction completes.
- Retire: instr_count increments by 1 on the clock edge leaving WRITEBACK, or leaving MEM for a STORE. It wraps modulo 2^COUNT_WIDTH.
- mem_ready is ignored outside MEM. Opcode is ignored outside DECODE (a latched copy is used afterwards).
- Strobes not listed for a state are 0. MemRead and MemWrite are never asserted together. RegWrite and MemWrite are never asserted together.

Test Plan:
- R-type: reset, run=1, Opcode=0110011 -> state sequence 0,1,2,4,0. RegWrite=1 only in state 4, ALUOp=10 in state 2, ALUSrc=0, MemtoReg=0. instr_count 0->1.
- LW with 2 wait states: Opcode=0000011, mem_ready low for 2 MEM cycles -> MemRead=1 for 3 cycles, then WRITEBACK with RegWrite=1 and MemtoReg=1. Total 7 cycles; instr_count +1.
- SW: Opcode=0100011, mem_ready=1 -> MemWrite=1 for one cycle in MEM, RegWrite never 1, return to FETCH after 4 cycles, count +1.
- Illegal: Opcode=1111111 -> illegal_instr pulses 1 cycle in DECODE, state back to 0, no RegWrite/MemWrite, count unchanged. run=0 -> controller stays in FETCH with pc_write=0.
- Reset mid-MEM: assert reset while in MEM with mem_ready=0 -> state=0 and all strobes 0 immediately (asynchronous), instr_count=0.
- Wrap: COUNT_WIDTH=4, retire 17 R-type instructions -> instr_count=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller for the RISC-V datapath: steps each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath control strobes.
module multicycle_controller #(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter logic [6:0]  OP_RTYPE    = 7'b0110011,
    parameter logic [6:0]  OP_ITYPE    = 7'b0010011,
    parameter logic [6:0]  OP_LOAD     = 7'b0000011,
    parameter logic [6:0]  OP_STORE    = 7'b0100011
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [6:0]             Opcode,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   MemtoReg,
    output logic                   MemWrite,
    output logic                   MemRead,
    output logic                   ALUSrc,
    output logic                   RegWrite,
    output logic [1:0]             ALUOp,
    output logic                   illegal_instr,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [6:0]             op_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   retire;

    logic is_rtype;
    logic is_load;
    logic is_store;
    logic is_memop;
    logic op_supported;

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_load  = (op_q == OP_LOAD);
    assign is_store = (op_q == OP_STORE);
    assign is_memop = is_load || is_store;

    assign op_supported = (Opcode == OP_RTYPE) || (Opcode == OP_ITYPE) ||
                          (Opcode == OP_LOAD)  || (Opcode == OP_STORE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= Opcode;
            end
            if (retire) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Strobes are forced low for the whole time reset is held, even in FETCH with run=1.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        MemtoReg      = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        ALUSrc        = 1'b0;
        RegWrite      = 1'b0;
        ALUOp         = 2'b00;
        illegal_instr = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (run && !reset) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (op_supported) begin
                    state_d = EXECUTE;
                end else begin
                    illegal_instr = !reset;
                    state_d       = FETCH;
                end
            end
            EXECUTE: begin
                ALUSrc  = !is_rtype;
                ALUOp   = is_memop ? 2'b00 : 2'b10;
                state_d = is_memop ? MEM : WRITEBACK;
            end
            MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                ALUSrc   = 1'b1;
                ALUOp    = 2'b00;
                if (mem_ready) begin
                    state_d = is_load ? WRITEBACK : FETCH;
                    retire  = is_store;
                end
            end
            WRITEBACK: begin
                RegWrite = 1'b1;
                MemtoReg = is_load;
                ALUSrc   = !is_rtype;
                ALUOp    = is_memop ? 2'b00 : 2'b10;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

    mem_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(MemRead && MemWrite));
    write_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(RegWrite && MemWrite));

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference model queues
// the expected outputs of every cycle and a monitor compares them at the falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [6:0] Opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite;
    logic [1:0] ALUOp;
    logic       illegal_instr;
    logic [2:0] state;
    logic [3:0] instr_count;

    multicycle_controller #(.COUNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .run(run), .Opcode(Opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .illegal_instr(illegal_instr), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pc;
        logic       ir;
        logic       m2r;
        logic       mw;
        logic       mr;
        logic       src;
        logic       rw;
        logic [1:0] aop;
        logic       ill;
        logic [3:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   model_count = 0;
    int   vectors = 0;
    int   fails = 0;
    int   cyc = 0;

    function automatic obs_t mk(input int st);
        obs_t e;
        e     = '0;
        e.st  = 3'(st);
        e.cnt = 4'(model_count % 16);
        return e;
    endfunction

    task automatic step(input logic r, input logic rn, input logic [6:0] op,
                        input logic rdy, input obs_t e);
        @(posedge clk);
        #1;
        reset     = r;
        run       = rn;
        Opcode    = op;
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    function automatic logic [6:0] junk_op();
        return 7'($urandom);
    endfunction

    function automatic logic coin();
        return 1'($urandom);
    endfunction

    // One instruction as the programmer sees it: fetch, decode, then the phases its type needs.
    task automatic do_instr(input logic [6:0] op, input int waits);
        obs_t e;
        logic ld, sw, rt, legal, memop;
        ld    = (op == OP_LW);
        sw    = (op == OP_SW);
        rt    = (op == OP_R);
        legal = ld || sw || rt || (op == OP_I);
        memop = ld || sw;

        e = mk(0); e.pc = 1'b1; e.ir = 1'b1;
        step(1'b0, 1'b1, junk_op(), coin(), e);

        e = mk(1); e.ill = !legal;
        step(1'b0, coin(), op, coin(), e);
        if (!legal) return;

        e = mk(2); e.src = !rt; e.aop = memop ? 2'b00 : 2'b10;
        step(1'b0, coin(), junk_op(), coin(), e);

        if (memop) begin
            for (int w = 0; w <= waits; w++) begin
                e = mk(3); e.mr = ld; e.mw = sw; e.src = 1'b1; e.aop = 2'b00;
                step(1'b0, coin(), junk_op(), (w == waits), e);
            end
            if (sw) model_count++;
        end

        if (!sw) begin
            e = mk(4); e.rw = 1'b1; e.m2r = ld; e.src = !rt; e.aop = memop ? 2'b00 : 2'b10;
            step(1'b0, coin(), junk_op(), coin(), e);
            model_count++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, junk_op(), coin(), mk(0));
    endtask

    initial begin : monitor
        obs_t e, act;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {state, pc_write, ir_write, MemtoReg, MemWrite, MemRead, ALUSrc,
                       RegWrite, ALUOp, illegal_instr, instr_count};
                vectors++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL cycle %0d: got st=%0d pc=%b ir=%b m2r=%b mw=%b mr=%b src=%b rw=%b aop=%b ill=%b cnt=%0d, expected st=%0d pc=%b ir=%b m2r=%b mw=%b mr=%b src=%b rw=%b aop=%b ill=%b cnt=%0d",
                             cyc, act.st, act.pc, act.ir, act.m2r, act.mw, act.mr, act.src,
                             act.rw, act.aop, act.ill, act.cnt, e.st, e.pc, e.ir, e.m2r,
                             e.mw, e.mr, e.src, e.rw, e.aop, e.ill, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        logic [6:0] op;
        obs_t       e;
        int         drain;

        step(1'b1, 1'b1, junk_op(), coin(), mk(0));
        idle(2);

        do_instr(OP_R, 0);
        do_instr(OP_LW, 2);
        do_instr(OP_SW, 0);
        do_instr(7'b1111111, 0);
        idle(3);
        do_instr(OP_I, 0);

        // Reset arrives mid-MEM of a stalled load: everything must drop before the next edge.
        e = mk(0); e.pc = 1'b1; e.ir = 1'b1;
        step(1'b0, 1'b1, junk_op(), 1'b0, e);
        step(1'b0, 1'b1, OP_LW, 1'b0, mk(1));
        e = mk(2); e.src = 1'b1;
        step(1'b0, 1'b1, junk_op(), 1'b0, e);
        e = mk(3); e.mr = 1'b1; e.src = 1'b1;
        step(1'b0, 1'b1, junk_op(), 1'b0, e);
        model_count = 0;
        @(posedge clk);
        #1;
        run = 1'b1;
        mem_ready = 1'b0;
        exp_q.push_back(mk(0));
        #1;
        reset = 1'b1;
        step(1'b1, 1'b1, junk_op(), 1'b1, mk(0));
        idle(1);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LW;
                3: op = OP_SW;
                4: begin
                    do op = junk_op();
                    while (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW);
                end
                default: op = OP_R;
            endcase
            do_instr(op, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected cycles never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
